// File: rtl/lp_sqrt_pkg.sv
// Shared types and sizing helpers for the pipelined square-root family.
package lp_sqrt_pkg;

    localparam int MAX_W  = 64;
    localparam int MAX_R  = 32;
    localparam int MAX_ID = 32;
    localparam int MAX_CENSUS_W = $clog2(MAX_R + 1);

    function automatic int root_w(input int width);
        return (width + 1) / 2;
    endfunction

    function automatic int iters_per_stage(input int width, input int stages);
        return (root_w(width) + stages - 1) / stages;
    endfunction

    // Iterations owned by 1-based stage k; trailing stages may get fewer or none.
    function automatic int stage_iters(input int width, input int stages, input int k);
        int left;
        left = root_w(width) - (k - 1) * iters_per_stage(width, stages);
        if (left < 0) left = 0;
        if (left > iters_per_stage(width, stages)) left = iters_per_stage(width, stages);
        return left;
    endfunction

    function automatic int census_w(input int stages);
        return (stages < MAX_R) ? $clog2(stages + 1) : MAX_CENSUS_W;
    endfunction

    typedef struct packed {
        logic              valid;
        logic [MAX_ID-1:0] id;
        logic [MAX_R-1:0]  root;
        logic [MAX_R:0]    rem;
        logic [MAX_W-1:0]  operand;
        logic              neg;
    } stage_t;

endpackage

// File: rtl/lp_sqrt_step.sv
// Combinational block running a fixed number of restoring square-root iterations.
module lp_sqrt_step #(
    parameter int rw    = 4,
    parameter int iters = 1
) (
    input  logic [rw-1:0]   cur_root,
    input  logic [rw:0]     cur_rem,
    input  logic [2*rw-1:0] cur_op,
    output logic [rw-1:0]   nxt_root,
    output logic [rw:0]     nxt_rem,
    output logic [2*rw-1:0] nxt_op
);

    always_comb begin
        logic [rw+2:0] acc;
        logic [rw+2:0] dvs;
        acc      = '0;
        dvs      = '0;
        nxt_root = cur_root;
        nxt_rem  = cur_rem;
        nxt_op   = cur_op;
        for (int i = 0; i < iters; i++) begin
            // Bring down the next operand bit pair and try subtracting 4*root+1.
            acc    = {nxt_rem, nxt_op[2*rw-1 -: 2]};
            dvs    = {1'b0, nxt_root, 2'b01};
            nxt_op = nxt_op << 2;
            if (acc >= dvs) begin
                acc      = acc - dvs;
                nxt_root = (nxt_root << 1) | rw'(1);
            end else begin
                nxt_root = nxt_root << 1;
            end
            nxt_rem = acc[rw:0];
        end
    end

endmodule

// File: rtl/lp_piped_sqrt_rem.sv
// Pipelined integer square root with remainder, tag tracking, bubble collapsing
// and a sticky dropped-launch flag.
module lp_piped_sqrt_rem
    import lp_sqrt_pkg::*;
#(
    parameter int width       = 8,
    parameter int id_width    = 8,
    parameter int stages      = 4,
    parameter int tc_mode     = 0,
    parameter int op_iso_mode = 1,
    localparam int R = root_w(width),
    localparam int C = census_w(stages)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [width-1:0]    a,
    input  logic                launch,
    input  logic [id_width-1:0] launch_id,
    input  logic                accept_n,
    input  logic                ovf_clr,
    output logic [R-1:0]        root,
    output logic [R:0]          rem,
    output logic                neg,
    output logic                arrive,
    output logic [id_width-1:0] arrive_id,
    output logic                push_out_n,
    output logic                pipe_full,
    output logic                pipe_ovf,
    output logic [C-1:0]        pipe_census
);

    stage_t          stage_q [1:stages];
    stage_t          src     [1:stages];
    logic [R-1:0]    nxt_root [1:stages];
    logic [R:0]      nxt_rem  [1:stages];
    logic [2*R-1:0]  nxt_op   [1:stages];
    logic [stages:1] move;
    logic            pop;
    logic            launch_ok;
    logic            a_neg;
    logic [C-1:0]    census_q;
    logic            ovf_q;

    assign pop       = stage_q[stages].valid & ~accept_n;
    assign pipe_full = (census_q == C'(stages)) & accept_n;
    assign launch_ok = launch & ~pipe_full;
    assign a_neg     = (tc_mode != 0) && a[width-1];

    // A stage takes new contents when it is empty or its occupant moves on.
    always_comb begin
        logic m;
        m    = pop;
        move = '0;
        for (int k = stages; k >= 1; k--) begin
            m       = ~stage_q[k].valid | m;
            move[k] = m;
        end
    end

    // Negative operands enter as zero so the recurrence yields root=0, rem=0.
    always_comb begin
        src[1]         = '0;
        src[1].valid   = launch_ok;
        src[1].id      = MAX_ID'(launch_id);
        src[1].neg     = a_neg;
        src[1].operand = a_neg ? '0 : MAX_W'(a);
        for (int k = 2; k <= stages; k++) src[k] = stage_q[k-1];
    end

    for (genvar k = 1; k <= stages; k++) begin : g_stage
        lp_sqrt_step #(
            .rw    (R),
            .iters (stage_iters(width, stages, k))
        ) u_step (
            .cur_root (src[k].root[R-1:0]),
            .cur_rem  (src[k].rem[R:0]),
            .cur_op   (src[k].operand[2*R-1:0]),
            .nxt_root (nxt_root[k]),
            .nxt_rem  (nxt_rem[k]),
            .nxt_op   (nxt_op[k])
        );
    end

    // Stage registers: data loads only with valid data unless isolation is off.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 1; k <= stages; k++) stage_q[k] <= '0;
        end else begin
            for (int k = 1; k <= stages; k++) begin
                if (move[k]) begin
                    stage_q[k].valid <= src[k].valid;
                    if (src[k].valid || op_iso_mode == 0) begin
                        stage_q[k].id      <= src[k].id;
                        stage_q[k].neg     <= src[k].neg;
                        stage_q[k].root    <= MAX_R'(nxt_root[k]);
                        stage_q[k].rem     <= (MAX_R + 1)'(nxt_rem[k]);
                        stage_q[k].operand <= MAX_W'(nxt_op[k]);
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            census_q <= '0;
            ovf_q    <= 1'b0;
        end else begin
            if (launch_ok && !pop)      census_q <= census_q + C'(1);
            else if (pop && !launch_ok) census_q <= census_q - C'(1);
            if (launch && pipe_full)    ovf_q <= 1'b1;
            else if (ovf_clr)           ovf_q <= 1'b0;
        end
    end

    assign root        = stage_q[stages].root[R-1:0];
    assign rem         = stage_q[stages].rem[R:0];
    assign neg         = stage_q[stages].neg;
    assign arrive      = stage_q[stages].valid;
    assign arrive_id   = stage_q[stages].id[id_width-1:0];
    assign push_out_n  = ~pop;
    assign pipe_ovf    = ovf_q;
    assign pipe_census = census_q;

endmodule

// File: tb/tb_lp_piped_sqrt_rem.sv
// Scoreboard bench: driver models occupancy and pushes expected results, monitor checks arrivals.
module tb_lp_piped_sqrt_rem;

    localparam int S = 4;

    logic       clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n, launch, accept_n, ovf_clr, launch_tc, tc_accept_n;
    logic [7:0] a, launch_id;
    logic [3:0] root, tc_root;
    logic [4:0] rem, tc_rem;
    logic       neg, arrive, push_out_n, pipe_full, pipe_ovf;
    logic       tc_neg, tc_arrive, tc_push_n, tc_full, tc_ovf;
    logic [7:0] arrive_id, tc_id;
    logic [2:0] pipe_census, tc_census;

    lp_piped_sqrt_rem #(.width(8), .id_width(8), .stages(S), .tc_mode(0), .op_iso_mode(1)) dut (
        .clk(clk), .rst_n(rst_n), .a(a), .launch(launch), .launch_id(launch_id),
        .accept_n(accept_n), .ovf_clr(ovf_clr), .root(root), .rem(rem), .neg(neg),
        .arrive(arrive), .arrive_id(arrive_id), .push_out_n(push_out_n),
        .pipe_full(pipe_full), .pipe_ovf(pipe_ovf), .pipe_census(pipe_census)
    );

    lp_piped_sqrt_rem #(.width(8), .id_width(8), .stages(S), .tc_mode(1), .op_iso_mode(1)) dut_tc (
        .clk(clk), .rst_n(rst_n), .a(a), .launch(launch_tc), .launch_id(launch_id),
        .accept_n(tc_accept_n), .ovf_clr(ovf_clr), .root(tc_root), .rem(tc_rem), .neg(tc_neg),
        .arrive(tc_arrive), .arrive_id(tc_id), .push_out_n(tc_push_n),
        .pipe_full(tc_full), .pipe_ovf(tc_ovf), .pipe_census(tc_census)
    );

    typedef struct {
        logic [3:0] root;
        logic [4:0] rem;
        logic       neg;
        logic [7:0] id;
    } exp_t;

    exp_t sb_q[$];
    int   pos_q[$];
    bit   m_ovf;
    int   n_tests = 0;
    int   n_fail  = 0;

    task automatic chk(input string nm, input longint act, input longint req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, req, $time);
        end
    endtask

    function automatic exp_t ref_model(input logic [7:0] v, input logic [7:0] id);
        exp_t e;
        int   r;
        r = 0;
        while ((r + 1) * (r + 1) <= int'(v)) r++;
        e.root = 4'(r);
        e.rem  = 5'(int'(v) - r * r);
        e.neg  = 1'b0;
        e.id   = id;
        return e;
    endfunction

    // One clock cycle: entered and left at a falling edge.
    task automatic cycle(input bit l, input logic [7:0] av, input logic [7:0] idv,
                         input bit an, input bit clr);
        bit head, full, popped;
        int lim;
        launch = l; a = av; launch_id = idv; accept_n = an; ovf_clr = clr;
        #1;
        head   = (pos_q.size() > 0) && (pos_q[0] == S);
        full   = (pos_q.size() == S) && an;
        popped = head && !an;
        chk("census",     pipe_census, pos_q.size());
        chk("pipe_full",  pipe_full, full);
        chk("arrive",     arrive, head);
        chk("push_out_n", push_out_n, !popped);
        chk("pipe_ovf",   pipe_ovf, m_ovf);
        if (popped) void'(pos_q.pop_front());
        // Each item moves one stage closer to the output unless blocked by the one ahead.
        lim = S;
        for (int i = 0; i < pos_q.size(); i++) begin
            int np;
            np = pos_q[i] + 1;
            if (np > lim) np = lim;
            pos_q[i] = np;
            lim = np - 1;
        end
        if (l && !full) begin
            pos_q.push_back(1);
            sb_q.push_back(ref_model(av, idv));
        end
        if (l && full) m_ovf = 1'b1;
        else if (clr)  m_ovf = 1'b0;
        @(negedge clk);
    endtask

    task automatic drain();
        for (int i = 0; i < 40 && pos_q.size() > 0; i++) cycle(0, 8'd0, 8'd0, 0, 0);
        chk("drain_empty", pos_q.size(), 0);
    endtask

    // Monitor: compare every consumed result against the head of the scoreboard.
    initial begin
        forever begin
            @(negedge clk);
            #2;
            if (rst_n && arrive && !accept_n) begin
                if (sb_q.size() == 0) begin
                    chk("unexpected_result", 1, 0);
                end else begin
                    exp_t e;
                    e = sb_q.pop_front();
                    chk("root",      root, e.root);
                    chk("rem",       rem, e.rem);
                    chk("neg",       neg, e.neg);
                    chk("arrive_id", arrive_id, e.id);
                end
            end
        end
    end

    initial begin
        rst_n = 1'b0; launch = 1'b0; launch_tc = 1'b0; tc_accept_n = 1'b0;
        accept_n = 1'b0; ovf_clr = 1'b0; a = '0; launch_id = '0; m_ovf = 1'b0;
        #1;
        chk("rst_arrive", arrive, 0);
        chk("rst_root", root, 0);
        chk("rst_rem", rem, 0);
        chk("rst_id", arrive_id, 0);
        chk("rst_push_n", push_out_n, 1);
        chk("rst_census", pipe_census, 0);
        chk("rst_ovf", pipe_ovf, 0);
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Single operand with latency check through the occupancy model.
        cycle(1, 8'd200, 8'h11, 0, 0);
        drain();

        // Back-to-back stream at full throughput.
        cycle(1, 8'd255, 8'h01, 0, 0);
        cycle(1, 8'd0,   8'h02, 0, 0);
        cycle(1, 8'd1,   8'h03, 0, 0);
        cycle(1, 8'd144, 8'h04, 0, 0);
        cycle(1, 8'd81,  8'h05, 0, 0);
        cycle(1, 8'd17,  8'h06, 0, 0);
        cycle(1, 8'd3,   8'h07, 0, 0);
        drain();

        // Fill while stalled, drop one, drain in order, then clear the flag.
        for (int i = 0; i < 4; i++) cycle(1, 8'(i * 60 + 5), 8'(8'h20 + i), 1, 0);
        cycle(1, 8'd99, 8'h2F, 1, 0);
        cycle(0, 8'd0, 8'd0, 1, 0);
        drain();
        cycle(0, 8'd0, 8'd0, 0, 1);
        cycle(0, 8'd0, 8'd0, 0, 0);

        // Bubble collapse under a held consumer.
        cycle(1, 8'd50, 8'h31, 1, 0);
        cycle(0, 8'd0,  8'd0,  1, 0);
        cycle(0, 8'd0,  8'd0,  1, 0);
        cycle(1, 8'd65, 8'h32, 1, 0);
        for (int i = 0; i < 5; i++) cycle(0, 8'd0, 8'd0, 1, 0);
        drain();

        // Randomized traffic with stalls, drops and clears.
        for (int i = 0; i < 400; i++)
            cycle($urandom_range(0, 9) < 6, 8'($urandom_range(0, 255)), 8'($urandom),
                  $urandom_range(0, 9) < 3, $urandom_range(0, 9) == 0);
        drain();
        cycle(0, 8'd0, 8'd0, 0, 1);

        // Asynchronous reset with three items in flight.
        cycle(1, 8'd10, 8'h41, 1, 0);
        cycle(1, 8'd20, 8'h42, 1, 0);
        cycle(1, 8'd30, 8'h43, 1, 0);
        launch = 1'b0; accept_n = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_arrive", arrive, 0);
        chk("mid_rst_root", root, 0);
        chk("mid_rst_rem", rem, 0);
        chk("mid_rst_id", arrive_id, 0);
        chk("mid_rst_push_n", push_out_n, 1);
        chk("mid_rst_full", pipe_full, 0);
        chk("mid_rst_census", pipe_census, 0);
        pos_q.delete(); sb_q.delete(); m_ovf = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        cycle(1, 8'd99, 8'h5A, 0, 0);
        drain();

        // Two's complement instance: negative operand flagged, positive computed.
        launch_tc = 1'b1;
        cycle(0, 8'h80, 8'h61, 0, 0);
        cycle(0, 8'h40, 8'h62, 0, 0);
        launch_tc = 1'b0;
        cycle(0, 8'd0, 8'd0, 0, 0);
        cycle(0, 8'd0, 8'd0, 0, 0);
        #1;
        chk("tc_arrive0", tc_arrive, 1);
        chk("tc_root0", tc_root, 0);
        chk("tc_rem0", tc_rem, 0);
        chk("tc_neg0", tc_neg, 1);
        chk("tc_id0", tc_id, 8'h61);
        cycle(0, 8'd0, 8'd0, 0, 0);
        #1;
        chk("tc_arrive1", tc_arrive, 1);
        chk("tc_root1", tc_root, 8);
        chk("tc_rem1", tc_rem, 0);
        chk("tc_neg1", tc_neg, 0);
        chk("tc_id1", tc_id, 8'h62);
        chk("tc_push_n", tc_push_n, 0);
        cycle(0, 8'd0, 8'd0, 0, 0);
        #1;
        chk("tc_census", tc_census, 0);
        chk("tc_full", tc_full, 0);
        chk("tc_ovf", tc_ovf, 0);

        @(negedge clk);
        #3;
        chk("scoreboard_empty", sb_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
